// File: rtl/kbd_pkg.sv
// kbd_pkg: shared definitions for the keyboard receive shifter.
//   kbd_state_e   : receive FSM state encoding
//   KBD_DATA_BITS : default data bits per XT frame
//   KBD_START_BIT : level of a valid XT start bit
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } kbd_state_e;

    localparam int unsigned KBD_DATA_BITS = 8;
    localparam logic        KBD_START_BIT = 1'b1;

endpackage : kbd_pkg

// File: rtl/kbd_shift_sync_edge.sv
// kbd_shift_sync_edge: multi-flop synchronizer for an asynchronous line plus a
// history flop for falling-edge detection.
//   clk, reset_n : system clock, async active-low reset (flops reset to 1 = idle line)
//   sig_i        : raw asynchronous input
//   sync_o       : synchronized level
//   fall_c       : high for one clk when the synchronized level goes 1 -> 0
//                  (gate of flop outputs only, no path from sig_i)
module kbd_shift_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_i,
    output logic sync_o,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Synchronizer chain and edge history; idle level of the lines is 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign fall_c = hist_q & ~sync_q[SYNC_STAGES-1];

endmodule : kbd_shift_sync_edge

// File: rtl/kbd_shift.sv
// kbd_shift: XT keyboard receive shifter. Assembles start(1) + DATA_BITS data
// bits (LSB first) sampled on kbd_clk falling edges, holds the scan code and
// raises irq until software clears it.
//   clk, reset_n    : system clock, async active-low reset
//   kbd_clk_in      : raw keyboard clock (async)
//   kbd_data_in     : raw keyboard data (async)
//   kbd_clr         : software clear/inhibit, level, active-high
//   scan_code       : last completed scan code
//   irq             : scan code available
//   kbd_data_hold_n : low = hold keyboard data line low (inhibit)
//   frame_err       : one-cycle pulse on bad start bit or timeout
module kbd_shift
    import kbd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_BITS   = KBD_DATA_BITS,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 kbd_clk_in,
    input  logic                 kbd_data_in,
    input  logic                 kbd_clr,
    output logic [DATA_BITS-1:0] scan_code,
    output logic                 irq,
    output logic                 kbd_data_hold_n,
    output logic                 frame_err
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

    logic clk_s;
    logic fall;
    logic data_s;
    logic data_fall_unused;

    kbd_shift_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (kbd_clk_in),
        .sync_o  (clk_s),
        .fall_c  (fall)
    );

    kbd_shift_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (kbd_data_in),
        .sync_o  (data_s),
        .fall_c  (data_fall_unused)
    );

    kbd_state_e           state_q,  state_d;
    logic [DATA_BITS-1:0] shreg_q,  shreg_d;
    logic [DATA_BITS-1:0] scan_q,   scan_d;
    logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
    logic [TMO_W-1:0]     tmo_q,    tmo_d;
    logic                 irq_q,    irq_d;
    logic                 hold_n_q, hold_n_d;
    logic                 ferr_q,   ferr_d;
    logic [DATA_BITS-1:0] shifted;

    // clk_s only feeds the edge detector.
    logic clk_s_unused;
    assign clk_s_unused = clk_s;

    // Next-state and next-output logic; kbd_clr overrides every state.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        scan_d   = scan_q;
        bitcnt_d = bitcnt_q;
        tmo_d    = tmo_q;
        irq_d    = irq_q;
        hold_n_d = 1'b1;
        ferr_d   = 1'b0;
        shifted  = {data_s, shreg_q[DATA_BITS-1:1]};

        if (kbd_clr) begin
            state_d  = IDLE;
            shreg_d  = '0;
            scan_d   = '0;
            bitcnt_d = '0;
            tmo_d    = '0;
            irq_d    = 1'b0;
            hold_n_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fall) begin
                        if (data_s == KBD_START_BIT) begin
                            state_d  = SHIFT;
                            bitcnt_d = '0;
                            tmo_d    = '0;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        // A fall always beats the timeout terminal count.
                        shreg_d  = shifted;
                        bitcnt_d = bitcnt_q + CNT_W'(1);
                        tmo_d    = '0;
                        if (bitcnt_q == CNT_W'(DATA_BITS - 1)) begin
                            // Publish on the same edge so irq lags the last fall by one clk.
                            state_d  = FULL;
                            scan_d   = shifted;
                            irq_d    = 1'b1;
                            hold_n_d = 1'b0;
                        end
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        state_d  = IDLE;
                        bitcnt_d = '0;
                        tmo_d    = '0;
                        ferr_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                FULL: begin
                    hold_n_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            scan_q   <= '0;
            bitcnt_q <= '0;
            tmo_q    <= '0;
            irq_q    <= 1'b0;
            hold_n_q <= 1'b1;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            scan_q   <= scan_d;
            bitcnt_q <= bitcnt_d;
            tmo_q    <= tmo_d;
            irq_q    <= irq_d;
            hold_n_q <= hold_n_d;
            ferr_q   <= ferr_d;
        end
    end

    assign scan_code       = scan_q;
    assign irq             = irq_q;
    assign kbd_data_hold_n = hold_n_q;
    assign frame_err       = ferr_q;

endmodule : kbd_shift

// File: tb/tb_kbd_shift.sv
// tb_kbd_shift: scoreboard bench for kbd_shift. Stimulus pushes expected scan
// codes / frame errors into queues; a negedge monitor pops and compares them.
module tb_kbd_shift;

    localparam int unsigned TMO  = 20000;
    localparam int unsigned HALF = 50;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       kbd_clk_in = 1'b1;
    logic       kbd_data_in = 1'b1;
    logic       kbd_clr = 1'b0;
    logic [7:0] scan_code;
    logic       irq;
    logic       kbd_data_hold_n;
    logic       frame_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_fall_cyc = 0;

    logic [7:0] exp_q[$];
    int         ferr_q[$];
    logic       irq_prev = 1'b0;
    logic       ferr_prev = 1'b0;

    kbd_shift #(.SYNC_STAGES(2), .DATA_BITS(8), .TIMEOUT_CYC(TMO)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .kbd_clk_in      (kbd_clk_in),
        .kbd_data_in     (kbd_data_in),
        .kbd_clr         (kbd_clr),
        .scan_code       (scan_code),
        .irq             (irq),
        .kbd_data_hold_n (kbd_data_hold_n),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: irq rising edge pops a scan code, frame_err pulse pops an error.
    always @(negedge clk) begin
        if (!reset_n) begin
            irq_prev  = 1'b0;
            ferr_prev = 1'b0;
        end else begin
            if (irq && !irq_prev) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_irq");
                end else begin
                    check("scan_code", int'(scan_code), int'(exp_q.pop_front()));
                    check("hold_n_at_irq", int'(kbd_data_hold_n), 0);
                    check("irq_latency", cyc - last_fall_cyc, 3);
                end
            end
            if (frame_err) begin
                if (ferr_prev) flag("frame_err_width");
                else if (ferr_q.size() == 0) flag("unexpected_frame_err");
                else void'(ferr_q.pop_front());
            end
            irq_prev  = irq;
            ferr_prev = frame_err;
        end
    end

    // One kbd_clk period of 100 clk, falling edge in the middle.
    task automatic send_bit(input logic b);
        @(negedge clk);
        kbd_data_in = b;
        repeat (HALF) @(negedge clk);
        kbd_clk_in = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        kbd_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        kbd_clr = 1'b1;
        repeat (2) @(negedge clk);
        kbd_clr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_empty(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && ferr_q.size() == 0) break;
            @(negedge clk);
        end
        check(name, exp_q.size() + ferr_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;

        // Reset and idle lines.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_scan_code", int'(scan_code), 8'h00);
        check("rst_irq", int'(irq), 0);
        check("rst_hold_n", int'(kbd_data_hold_n), 1);
        check("rst_frame_err", int'(frame_err), 0);

        // Valid frame 0x1C.
        exp_q.push_back(8'h1C);
        send_frame(8'h1C);
        wait_empty("sb_1c", 50);
        check("full_irq", int'(irq), 1);
        check("full_hold_n", int'(kbd_data_hold_n), 0);

        // Second frame while FULL is ignored.
        send_frame(8'h9C);
        repeat (5) @(negedge clk);
        check("full_keeps_code", int'(scan_code), 8'h1C);
        check("full_keeps_irq", int'(irq), 1);

        // Clear for 2 clk, then hold_n returns one clk after the clear drops.
        @(negedge clk);
        kbd_clr = 1'b1;
        repeat (2) @(negedge clk);
        kbd_clr = 1'b0;
        check("clr_irq", int'(irq), 0);
        check("clr_scan_code", int'(scan_code), 8'h00);
        check("clr_hold_n_low", int'(kbd_data_hold_n), 0);
        @(negedge clk);
        check("clr_hold_n_back", int'(kbd_data_hold_n), 1);

        exp_q.push_back(8'h9C);
        send_frame(8'h9C);
        wait_empty("sb_9c", 50);
        clr_pulse();

        // Bad start bit: frame_err, stays IDLE (next frame decodes cleanly).
        ferr_q.push_back(1);
        send_bit(1'b0);
        wait_empty("sb_bad_start", 50);
        check("bad_start_irq", int'(irq), 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55);
        wait_empty("sb_55", 50);
        clr_pulse();

        // Partial frame then timeout.
        ferr_q.push_back(2);
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (TMO - 300) @(negedge clk);
        check("timeout_not_early", ferr_q.size(), 1);
        wait_empty("sb_timeout", 600);
        check("timeout_irq", int'(irq), 0);
        exp_q.push_back(8'h2A);
        send_frame(8'h2A);
        wait_empty("sb_2a", 50);
        clr_pulse();

        // Clear coincident with the 8th data fall: no irq.
        d = 8'hC3;
        send_bit(1'b1);
        for (int i = 0; i < 7; i++) send_bit(d[i]);
        @(negedge clk);
        kbd_data_in = d[7];
        repeat (HALF) @(negedge clk);
        kbd_clk_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        kbd_clr = 1'b1;
        repeat (2) @(negedge clk);
        kbd_clr = 1'b0;
        repeat (HALF) @(negedge clk);
        kbd_clk_in = 1'b1;
        repeat (5) @(negedge clk);
        check("clr_vs_fall_irq", int'(irq), 0);
        check("clr_vs_fall_code", int'(scan_code), 8'h00);

        // Receive 0x3D, then reset mid-frame: outputs reset without a clock edge.
        exp_q.push_back(8'h3D);
        send_frame(8'h3D);
        wait_empty("sb_3d", 50);
        send_bit(1'b1);
        send_bit(1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("amid_rst_scan_code", int'(scan_code), 8'h00);
        check("amid_rst_irq", int'(irq), 0);
        check("amid_rst_hold_n", int'(kbd_data_hold_n), 1);
        check("amid_rst_frame_err", int'(frame_err), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.push_back(8'h81);
        send_frame(8'h81);
        wait_empty("sb_81", 50);

        check("final_scan_q", exp_q.size(), 0);
        check("final_ferr_q", ferr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_kbd_shift

// File: doc/kbd_shift.md
Name: kbd_shift

Overview:
- Keyboard receive shifter for the PC system board; upstream feeder of the octal tristate bus driver that places the scan code on the data bus.
- Samples the asynchronous keyboard clock/data lines in the system clock domain and assembles an XT-style frame: start bit = 1, then 8 data bits LSB first.
- Holds the received scan code and raises an interrupt request until software clears it.
- scan_code[3:0] and scan_code[7:4] drive the two nibble inputs of the downstream buffer.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer; legal values 2..3.
- DATA_BITS, 8, number of data bits per frame.
- TIMEOUT_CYC, 20000, clk cycles without a kbd_clk falling edge, while in SHIFT, before the frame is aborted.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous, active-low reset.
- kbd_clk_in  input  1  raw keyboard clock, asynchronous to clk.
- kbd_data_in  input  1  raw keyboard data, asynchronous to clk.
- kbd_clr  input  1  software clear/inhibit, level sensitive, active-high.
- scan_code  output  DATA_BITS  last completed scan code.
- irq  output  1  scan code available.
- kbd_data_hold_n  output  1  low = hold the keyboard data line low (inhibit further transmission).
- frame_err  output  1  one-cycle pulse on a bad start bit or a timeout.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; scan_code=0; irq=0; kbd_data_hold_n=1; frame_err=0.
  - Shift register, bit counter and timeout counter all 0.
  - All synchronizer flops reset to 1, the idle level of the lines.
- Synchronizers: both inputs pass through SYNC_STAGES flops, plus one history flop on the clock path.
  - fall = hist & ~clk_s.
  - On a fall cycle, the sampled bit is the synchronized data value in that same cycle.
- State machine:
  - IDLE: on fall, if data_s=1 (valid start bit) -> SHIFT with bitcnt=0 and timeout=0. If data_s=0 -> pulse frame_err and stay in IDLE.
  - SHIFT:
    - On each fall: shreg = {data_s, shreg[DATA_BITS-1:1]}; bitcnt increments.
    - On the fall that brings bitcnt to DATA_BITS, move to FULL. In the next clk cycle, scan_code gets the completed shreg and irq goes to 1 simultaneously. Latency is exactly 1 clk after the final fall cycle.
    - Timeout increments every cycle without a fall and clears on each fall. When it reaches TIMEOUT_CYC-1 with no fall -> IDLE and pulse frame_err; scan_code and irq are unchanged.
  - FULL:
    - irq=1 and kbd_data_hold_n=0.
    - kbd_clk falls are ignored; scan_code is stable.
    - Leaves only through kbd_clr.
- kbd_clr=1 has priority over everything above, in any state:
  - Next clock: state=IDLE, irq=0, scan_code=0, shreg=0, counters=0, kbd_data_hold_n=0.
  - While kbd_clr stays high, falls are ignored and the block stays in IDLE.
  - On the first cycle after kbd_clr drops, kbd_data_hold_n returns to 1.
- Simultaneous events:
  - kbd_clr together with the final fall: the clear wins and no irq is produced.
  - Fall together with the timeout terminal count: the fall wins and the timeout counter resets.
- reset_n asserted mid-frame aborts immediately; there is no partial scan_code update.
- All outputs are registered; no combinational path from any input to any output.
- Counter widths: bitcnt uses $clog2(DATA_BITS+1); the timeout counter uses $clog2(TIMEOUT_CYC).

Decomposition:
- Shared package kbd_pkg holds:
  - state encoding: IDLE=2'd0, SHIFT=2'd1, FULL=2'd2;
  - constants KBD_DATA_BITS=8 and KBD_START_BIT=1'b1.
- One natural sub-module, sync_edge: a SYNC_STAGES synchronizer plus the history flop, giving data_s and fall outputs.
  - Instantiated once for the clock path.
  - The data path uses the same synchronizer with the edge output unused.

Test Plan:
- Reset then idle lines: reset_n low for 3 clk, then high, no activity -> scan_code=8'h00, irq=0, kbd_data_hold_n=1, frame_err=0.
- Valid frame, start=1 then bits of 8'h1C LSB first, kbd_clk period 100 clk -> scan_code=8'h1C and irq=1 exactly 1 clk after the final fall cycle; kbd_data_hold_n=0.
- In FULL, send a second frame for 8'h9C -> scan_code stays 8'h1C. Pulse kbd_clr for 2 clk -> irq=0 and scan_code=8'h00; kbd_data_hold_n=1 one clk after the clear ends. A new frame for 8'h9C is then received correctly.
- Start bit 0 -> single-cycle frame_err pulse, state stays IDLE, irq=0.
- 4 bits delivered, then kbd_clk held high for TIMEOUT_CYC cycles -> frame_err pulse. A following full 8'h2A frame yields scan_code=8'h2A (no bit-count carry-over).
- kbd_clr raised on the same cycle as the 8th data fall -> irq stays 0. Separately, reset_n dropped mid-frame -> all outputs at reset values within the same cycle.
